// File: rtl/rtc_pkg.sv
// rtc_pkg
// Shared definitions for the RTC parameter editor: field index map, per-field
// legal ranges, calendar helper, BCD conversion and the editor FSM states.
// Field values are kept as 7-bit binary; BCD is produced only at the outputs.
package rtc_pkg;

  localparam int F_S  = 0;  // seconds
  localparam int F_M  = 1;  // minutes
  localparam int F_H  = 2;  // hours (0-23 internally)
  localparam int F_D  = 3;  // day of month
  localparam int F_ME = 4;  // month
  localparam int F_A  = 5;  // year offset from 2000
  localparam int F_ST = 6;  // timer seconds
  localparam int F_MT = 7;  // timer minutes
  localparam int F_HT = 8;  // timer hours (never reformatted)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Year offset 00-99 maps to 2000-2099, so every multiple of 4 is a leap year.
  function automatic logic [6:0] days_in_month(input logic [6:0] month,
                                               input logic [6:0] year);
    logic [6:0] dim;
    case (month)
      7'd2:                    dim = ((year % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: dim = 7'd30;
      default:                 dim = 7'd31;
    endcase
    return dim;
  endfunction

  function automatic logic [6:0] field_min(input int idx);
    return (idx == F_D || idx == F_ME) ? 7'd1 : 7'd0;
  endfunction

  // Day returns its absolute ceiling; the editor substitutes days_in_month.
  function automatic logic [6:0] field_max(input int idx);
    logic [6:0] mx;
    case (idx)
      F_S, F_M, F_ST, F_MT: mx = 7'd59;
      F_H, F_HT:            mx = 7'd23;
      F_D:                  mx = 7'd31;
      F_ME:                 mx = 7'd12;
      default:              mx = 7'd99;
    endcase
    return mx;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] units;
    tens  = v / 7'd10;
    units = v % 7'd10;
    return {tens[3:0], units[3:0]};
  endfunction

endpackage

// File: rtl/rtc_btn_repeat.sv
// rtc_btn_repeat
// Rising-edge detect and hold-to-repeat for an up/down button pair.
// Ports:
//   clk, rst              clock, async active-high reset
//   tick                  slow enable pulse that paces auto-repeat
//   up, down              debounced button levels
//   enable                when low the repeat counter clears and no steps issue
//   step_up, step_down    one-cycle step requests
module rtc_btn_repeat #(
  parameter int DELAY = 4,
  parameter int RATE  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic up,
  input  logic down,
  input  logic enable,
  output logic step_up,
  output logic step_down
);

  localparam int CW = $clog2(((DELAY > RATE) ? DELAY : RATE) + 1);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic          up_q;
  logic          down_q;
  logic [CW-1:0] cnt;   // 0 = idle, otherwise ticks left until the next step
  logic          single;
  logic          press;
  logic          fire;

  assign single = up ^ down;
  assign press  = single & (up ? ~up_q : ~down_q);
  assign fire   = tick & (cnt == CNT_ONE);

  assign step_up   = enable & single & up   & (press | fire);
  assign step_down = enable & single & down & (press | fire);

  // Previous samples reset high so a button held through reset is not
  // mistaken for a fresh press once reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q   <= 1'b1;
      down_q <= 1'b1;
      cnt    <= '0;
    end else begin
      up_q   <= up;
      down_q <= down;
      if (!enable || !single) begin
        cnt <= '0;
      end else if (press) begin
        cnt <= CW'(DELAY);
      end else if (tick && cnt != '0) begin
        cnt <= (cnt == CNT_ONE) ? CW'(RATE) : cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/rtc_param_editor.sv
// rtc_param_editor
// Front-panel editor for RTC time/date/timer parameters. A field is selected
// with sel_up/sel_down and stepped with num_up/num_down (with hold-to-repeat);
// load commits the edit and raises a sticky done flag.
// Ports:
//   clk, rst            clock, async active-high reset
//   tick                2 Hz enable, paces auto-repeat only
//   en                  edit enable; buttons and load ignored when low
//   sel_up, sel_down    field selection buttons (levels)
//   num_up, num_down    value step buttons (levels)
//   fmt_12h             hour output format, 1 = 12 h with PM in bit 5
//   load, clr_done      commit request, done clear
//   fields              packed BCD values, field i at [8i+7:8i]
//   sel_onehot          currently selected field
//   done                sticky commit flag
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | editing disabled, waiting for en
// ST_EDIT   | buttons active; load edge moves to ST_COMMIT
// ST_COMMIT | single cycle: set done, return selection to field 0
//
// Field indices d, me and a are assumed present (NUM_FIELDS >= 9).
module rtc_param_editor
  import rtc_pkg::*;
#(
  parameter int NUM_FIELDS   = 9,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    en,
  input  logic                    sel_up,
  input  logic                    sel_down,
  input  logic                    num_up,
  input  logic                    num_down,
  input  logic                    fmt_12h,
  input  logic                    load,
  input  logic                    clr_done,
  output logic [8*NUM_FIELDS-1:0] fields,
  output logic [NUM_FIELDS-1:0]   sel_onehot,
  output logic                    done
);

  localparam int SW = $clog2(NUM_FIELDS);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_FIELDS - 1);

  state_t        state, state_n;
  logic [SW-1:0] sel, sel_n;
  logic [6:0]    val   [NUM_FIELDS];
  logic [6:0]    val_n [NUM_FIELDS];

  logic sel_up_q, sel_down_q, load_q;
  logic su_edge, sd_edge, load_edge;
  logic edit_act, load_go, sel_any, num_enable;
  logic step_up, step_down;

  logic [6:0] cur, lo, hi, d_max;
  logic [6:0] hour, hour12;
  logic [7:0] hour_fmt;

  assign su_edge   = sel_up   & ~sel_up_q;
  assign sd_edge   = sel_down & ~sel_down_q;
  assign load_edge = load     & ~load_q;

  // Edge registers reset high for the same reason as in rtc_btn_repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_up_q   <= 1'b1;
      sel_down_q <= 1'b1;
      load_q     <= 1'b1;
    end else begin
      sel_up_q   <= sel_up;
      sel_down_q <= sel_down;
      load_q     <= load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Priority inside EDIT: load edge, then selection edges, then num buttons.
  always_comb begin
    state_n    = state;
    edit_act   = 1'b0;
    load_go    = 1'b0;
    sel_any    = 1'b0;
    num_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_n = ST_EDIT;
      end
      ST_EDIT: begin
        edit_act   = en;
        load_go    = en & load_edge;
        sel_any    = en & ~load_edge & (su_edge | sd_edge);
        num_enable = en & ~load_edge & ~(su_edge | sd_edge);
        if (!en)          state_n = ST_IDLE;
        else if (load_go) state_n = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_n = en ? ST_EDIT : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  rtc_btn_repeat #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_num_rpt (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .up        (num_up),
    .down      (num_down),
    .enable    (num_enable),
    .step_up   (step_up),
    .step_down (step_down)
  );

  always_comb begin
    sel_n = sel;
    if (su_edge && !sd_edge)      sel_n = (sel == SEL_LAST) ? '0 : sel + 1'b1;
    else if (sd_edge && !su_edge) sel_n = (sel == '0) ? SEL_LAST : sel - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     sel <= '0;
    else if (state == ST_COMMIT) sel <= '0;
    else if (sel_any)            sel <= sel_n;
  end

  // Day is re-clamped against the possibly updated month/year every cycle so
  // a month or year step pulls an out-of-range day down in the same cycle.
  always_comb begin
    val_n = val;
    cur   = val[sel];
    lo    = field_min(int'(sel));
    hi    = (int'(sel) == F_D) ? days_in_month(val[F_ME], val[F_A])
                               : field_max(int'(sel));
    if (step_up)        val_n[sel] = (cur >= hi) ? lo : cur + 7'd1;
    else if (step_down) val_n[sel] = (cur <= lo) ? hi : cur - 7'd1;
    d_max = days_in_month(val_n[F_ME], val_n[F_A]);
    if (val_n[F_D] > d_max) val_n[F_D] = d_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIELDS; i++) val[i] <= field_min(i);
    end else begin
      val <= val_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     done <= 1'b0;
    else if (state == ST_COMMIT) done <= 1'b1;
    else if (clr_done)           done <= 1'b0;
  end

  // 12 h display: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  assign hour     = val[F_H];
  assign hour12   = (hour == 7'd0) ? 7'd12 : (hour > 7'd12) ? hour - 7'd12 : hour;
  assign hour_fmt = to_bcd(hour12) | ((hour >= 7'd12) ? 8'h20 : 8'h00);

  always_comb begin
    fields = '0;
    for (int i = 0; i < NUM_FIELDS; i++) fields[8*i +: 8] = to_bcd(val[i]);
    if (fmt_12h) fields[8*F_H +: 8] = hour_fmt;
  end

  assign sel_onehot = NUM_FIELDS'(1) << sel;

endmodule

// File: tb/tb_rtc_param_editor.sv
module tb_rtc_param_editor;

  localparam int NF = 9;
  localparam int RD = 4;
  localparam int RR = 1;

  logic clk = 1'b0;
  logic rst, tick, en, sel_up, sel_down, num_up, num_down, fmt_12h, load, clr_done;
  logic [8*NF-1:0] fields;
  logic [NF-1:0]   sel_onehot;
  logic            done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: plain integer field values, selected index, done flag.
  int mval [NF];
  int msel;
  int mdone;

  rtc_param_editor #(
    .NUM_FIELDS   (NF),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .en         (en),
    .sel_up     (sel_up),
    .sel_down   (sel_down),
    .num_up     (num_up),
    .num_down   (num_down),
    .fmt_12h    (fmt_12h),
    .load       (load),
    .clr_done   (clr_done),
    .fields     (fields),
    .sel_onehot (sel_onehot),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic int m_dim(int me, int a);
    int days [12];
    days = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (me == 2 && a % 4 == 0) return 29;
    return days[me - 1];
  endfunction

  function automatic int m_min(int i);
    return (i == 3 || i == 4) ? 1 : 0;
  endfunction

  function automatic int m_max(int i);
    case (i)
      0, 1, 6, 7: return 59;
      2, 8:       return 23;
      3:          return m_dim(mval[4], mval[5]);
      4:          return 12;
      default:    return 99;
    endcase
  endfunction

  function automatic int m_bcd(int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic logic [8*NF-1:0] exp_fields();
    logic [8*NF-1:0] r;
    int b;
    int h12;
    r = '0;
    for (int i = 0; i < NF; i++) begin
      b = m_bcd(mval[i]);
      if (i == 2 && fmt_12h) begin
        h12 = mval[2] % 12;
        if (h12 == 0) h12 = 12;
        b = m_bcd(h12) + ((mval[2] >= 12) ? 32 : 0);
      end
      r[8*i +: 8] = 8'(b);
    end
    return r;
  endfunction

  function automatic logic [NF-1:0] exp_sel();
    logic [NF-1:0] s;
    s = '0;
    s[msel] = 1'b1;
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NF; i++) mval[i] = m_min(i);
    msel  = 0;
    mdone = 0;
  endtask

  task automatic m_step(input int up);
    int i, lo, hi, dmax;
    i  = msel;
    lo = m_min(i);
    hi = m_max(i);
    if (up != 0) mval[i] = (mval[i] == hi) ? lo : mval[i] + 1;
    else         mval[i] = (mval[i] == lo) ? hi : mval[i] - 1;
    if (i == 4 || i == 5) begin
      dmax = m_dim(mval[4], mval[5]);
      if (mval[3] > dmax) mval[3] = dmax;
    end
  endtask

  task automatic chk(input string tag, input logic [8*NF-1:0] obs, input logic [8*NF-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".fields"}, fields, exp_fields());
    chk({tag, ".sel"}, {63'd0, sel_onehot}, {63'd0, exp_sel()});
    chk({tag, ".done"}, {71'd0, done}, 72'(mdone));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0 sel_up, 1 sel_down, 2 num_up, 3 num_down, 4 load: one-cycle press.
  task automatic pulse(input int which);
    case (which)
      0:       sel_up   = 1'b1;
      1:       sel_down = 1'b1;
      2:       num_up   = 1'b1;
      3:       num_down = 1'b1;
      default: load     = 1'b1;
    endcase
    step();
    sel_up = 1'b0; sel_down = 1'b0; num_up = 1'b0; num_down = 1'b0; load = 1'b0;
    step();
    if (en) begin
      case (which)
        0:       msel = (msel + 1) % NF;
        1:       msel = (msel + NF - 1) % NF;
        2:       m_step(1);
        3:       m_step(0);
        default: begin mdone = 1; msel = 0; end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; en = 1'b0; sel_up = 1'b0; sel_down = 1'b0;
    num_up = 1'b0; num_down = 1'b0; fmt_12h = 1'b0; load = 1'b0; clr_done = 1'b0;
    m_reset();
    step(); step();
    chk_all("reset");
    chk("reset_bytes", fields, 72'h00_00_00_00_01_01_00_00_00);

    rst = 1'b0;
    en  = 1'b1;
    step();

    // Minutes: 00 -> 59 -> 58 by stepping down, then up through the wrap.
    pulse(0);
    pulse(3); pulse(3);
    chk("m58", {64'd0, fields[15:8]}, 72'h58);
    pulse(2);
    chk("m59", {64'd0, fields[15:8]}, 72'h59);
    chk_all("m59");
    pulse(2);
    chk("m00", {64'd0, fields[15:8]}, 72'h00);

    // Day clamp on month change, non-leap then leap year.
    pulse(0); pulse(0);
    pulse(3);
    chk("d31", {64'd0, fields[31:24]}, 72'h31);
    pulse(0); pulse(0); pulse(2);
    pulse(1); pulse(2);
    chk("me02", {64'd0, fields[39:32]}, 72'h02);
    chk("d28", {64'd0, fields[31:24]}, 72'h28);
    chk_all("clamp28");
    pulse(3);
    pulse(1);
    for (int i = 0; i < 3; i++) pulse(2);
    pulse(0); pulse(0);
    for (int i = 0; i < 3; i++) pulse(2);
    pulse(1); pulse(2);
    chk("d29", {64'd0, fields[31:24]}, 72'h29);
    chk_all("clamp29");

    // Hour formatting.
    pulse(1); pulse(1);
    for (int i = 0; i < 13; i++) pulse(2);
    fmt_12h = 1'b1;
    #1;
    chk("h13_12h", {64'd0, fields[23:16]}, 72'h21);
    for (int i = 0; i < 11; i++) pulse(2);
    chk("h00_12h", {64'd0, fields[23:16]}, 72'h12);
    fmt_12h = 1'b0;
    for (int i = 0; i < 11; i++) pulse(3);
    chk("h13_24h", {64'd0, fields[23:16]}, 72'h13);
    chk_all("hour");

    // Edits ignored while en is low.
    en = 1'b0;
    pulse(2);
    chk_all("en_low");
    en = 1'b1;
    step();

    // Hold-to-repeat on seconds.
    pulse(1); pulse(1);
    num_up = 1'b1;
    step();
    m_step(1);
    chk("hold_edge", {64'd0, fields[7:0]}, 72'h01);
    for (int k = 1; k <= 10; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      mval[0] = 1 + ((k >= RD) ? ((k - RD) / RR + 1) : 0);
      chk_all($sformatf("hold_tick%0d", k));
    end
    chk("hold_end", {64'd0, fields[7:0]}, 72'h08);
    num_up = 1'b0;
    step();

    // Selection wrap downward, then load beats a simultaneous num_up.
    pulse(1);
    chk("sel_wrap", {63'd0, sel_onehot}, {63'd0, 9'b1_0000_0000});
    load = 1'b1; num_up = 1'b1;
    step();
    load = 1'b0; num_up = 1'b0;
    chk("done_lat", {71'd0, done}, 72'd0);
    step();
    mdone = 1; msel = 0;
    chk_all("commit");
    clr_done = 1'b1;
    step();
    clr_done = 1'b0;
    mdone = 0;
    chk("clr_done", {71'd0, done}, 72'd0);

    // Commit while clr_done is held: set wins.
    clr_done = 1'b1;
    pulse(4);
    clr_done = 1'b0;
    chk("set_wins", {71'd0, done}, 72'd1);

    // Randomised editing against the model.
    for (int r = 0; r < 60; r++) begin
      fmt_12h = 1'($urandom_range(0, 1));
      pulse(int'($urandom_range(0, 3)));
      chk_all($sformatf("rnd%0d", r));
    end

    // Reset in the middle of a hold.
    pulse(4);
    num_up = 1'b1;
    step();
    m_step(1);
    rst = 1'b1;
    #2;
    m_reset();
    chk_all("async_rst");
    step(); step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    chk_all("held_after_rst");
    num_up = 1'b0;
    step();
    pulse(2);
    chk_all("repress");
    chk("repress_s", {64'd0, fields[7:0]}, 72'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_param_editor.md
# rtc_param_editor

Parametrised front-panel editor for the RTC configuration path. It holds NUM_FIELDS BCD parameters (time, date, timer) and lets the user select a field and step its value up or down. Each field has its own legal range, wraps at the range ends, and supports hold-to-repeat. Day-of-month is range-checked against the edited month and year. A load request latches a sticky done flag for the RTC write sequencer downstream.

## Interface
- NUM_FIELDS, 9: number of editable fields; index map 0 s, 1 m, 2 h, 3 d, 4 me, 5 a, 6 st, 7 mt, 8 ht; indices ≥9 use range 0–99.
- REPEAT_DELAY, 4: tick pulses a num button must be held before auto-repeat starts.
- REPEAT_RATE, 1: tick pulses between auto-repeat steps.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle enable from the 2 Hz prescaler; times auto-repeat only.
- en  in  1  edit enable; when low, all buttons and load are ignored.
- sel_up, sel_down  in  1  level, debounced, synchronous: move field selection.
- num_up, num_down  in  1  level, debounced, synchronous: step the selected field.
- fmt_12h  in  1  hour output format: 1 = 12 h, 0 = 24 h.
- load  in  1  level: commit the edit.
- clr_done  in  1  clears done.
- fields  out  8*NUM_FIELDS  packed BCD values; field i is bits [8i+7:8i].
- sel_onehot  out  NUM_FIELDS  one-hot currently selected field.
- done  out  1  sticky commit flag.

## Operation
- Reset values: every field at its minimum (s/m/h/a/timers 00, d 01, me 01); sel_onehot = field 0; done = 0; FSM in IDLE.
- FSM states:
  - IDLE: go to EDIT when en = 1.
  - EDIT: buttons active. Go to IDLE when en = 0. On a load rising edge, go to COMMIT.
  - COMMIT: one cycle. Sets done. Selection returns to field 0. Go to EDIT, or to IDLE if en = 0.
- Buttons act on their rising edge, detected against the previous-cycle sample.
- Priority within one cycle: load > sel_* > num_*. Lower-priority edges in that cycle are discarded.
- Selection stepping:
  - sel_up steps the index +1 and wraps NUM_FIELDS-1 → 0.
  - sel_down steps −1 and wraps 0 → NUM_FIELDS-1.
  - sel_up and sel_down together: no move.
- Value stepping:
  - num_up adds 1 and wraps max → min. num_down subtracts 1 and wraps min → max.
  - num_up and num_down together: no change, and the repeat counter clears.
  - Arithmetic is on a 7-bit binary shadow per field. BCD is derived combinationally: tens = v/10, units = v%10.
- Ranges:
  - s, m, st, mt: 0–59.
  - h, ht: 0–23.
  - me: 1–12.
  - a: 0–99, representing years 2000–2099.
  - d: 1 to days_in_month(me, a). February has 29 days when a%4 = 0.
- Day clamp: if a change to me or a makes d exceed the new maximum, d is set to that maximum in the same cycle.
- Hour in 12 h mode:
  - The internal h stays 0–23. Only the output is reformatted.
  - Output bits [4:0] are BCD 12, 01–11; bit 5 = PM (internal h ≥ 12); bits [7:6] = 0.
  - ht is never reformatted.
- Auto-repeat:
  - While exactly one num button is held, tick pulses are counted.
  - After REPEAT_DELAY ticks, the field steps once per REPEAT_RATE ticks.
  - The counter clears on button release, on a selection change, or on leaving EDIT.
- done: set in COMMIT; cleared by clr_done. If both occur in the same cycle, set wins.

## Timing
- Button edge at cycle n → new field value or selection visible at n+1 (one register stage).
- load edge at cycle n → COMMIT at n+1 → done = 1 and selection at field 0 from n+2.
- Auto-repeat steps land on the cycle after the qualifying tick.
- en falling mid-hold: repeat stops immediately, and values hold their last committed-or-edited contents.
- rst asserted at any time forces the reset values asynchronously. Release is synchronous to clk.

## Structure
- Shared package rtc_pkg holds:
  - field index constants (F_S … F_HT);
  - field_min / field_max functions;
  - days_in_month function;
  - FSM state enum.
- Sub-module rtc_btn_repeat: edge detect plus REPEAT_DELAY/REPEAT_RATE counter. It outputs one step pulse per direction and is instantiated for the num pair. The sel pair uses edge detect only.

## Test plan
- Reset, then en = 1, select field 1 (m) at 58, two num_up edges: fields[15:8] = 0x59, then 0x00.
- d = 31, me = 1; select me, one num_up edge: me = 0x02, d clamps to 0x28 (a = 0x01) or 0x29 (a = 0x04).
- h = 13, fmt_12h = 1: hour byte = 0x21 (PM, 01). Set h = 0: byte = 0x12. fmt_12h = 0, h = 13: byte = 0x13.
- Hold num_up on s from 00 for 10 ticks with REPEAT_DELAY = 4, REPEAT_RATE = 1: s = 01 from the edge, then +1 per tick from the 4th tick, ending at 0x08.
- sel_down from field 0: sel_onehot = 9'b1_0000_0000. Pulse load and num_up in the same cycle: no value change, done = 1 two cycles later, selection at field 0. clr_done: done = 0.
- Assert rst mid-hold with fields edited: all fields return to their minima immediately and done = 0. After release, the held button produces no step until it is released and pressed again.
